// File: rtl/seq_shifter.sv
// -----------------------------------------------------------------------------
// seq_shifter
// Multi-cycle shift/rotate unit for the ALU datapath. A request (operand,
// operation, amount) is taken over a valid/ready handshake, shifted one
// position per clock, and the result is presented with zero/carry flags
// through a held valid/ready output handshake.
//
// Optional build macro:
//   SEQ_SHIFTER_BARREL_EN - compute the whole shift combinationally at capture
//                           and go straight to DONE (1-edge latency). Results
//                           are bit-identical to the iterative path.
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   in_valid / in_ready   request handshake
//   in_a [WIDTH]          operand
//   in_op [3]             000 pass, 001 ROR, 010 ROL, 011 SRL, 100 SLL,
//                         101 SRA, 110/111 pass
//   in_amt [AMT_W]        number of single-bit steps
//   out_valid / out_ready result handshake; result held until accepted
//   out_y [WIDTH]         result
//   out_zero              out_y == 0
//   out_carry             last bit shifted/rotated out (0 if no step taken)
//   busy                  unit not idle
// -----------------------------------------------------------------------------
module seq_shifter #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [2:0]       in_op,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_carry,
    output logic             busy
);

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ROR  = 3'b001;
    localparam logic [2:0] OP_ROL  = 3'b010;
    localparam logic [2:0] OP_SRL  = 3'b011;
    localparam logic [2:0] OP_SLL  = 3'b100;
    localparam logic [2:0] OP_SRA  = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One single-position step; returns {carry, register}.
    function automatic logic [WIDTH:0] step_f(input logic [2:0]       op,
                                              input logic [WIDTH-1:0] r);
        logic [WIDTH:0] res;
        case (op)
            OP_ROR:  res = {r[0],       r[0],       r[WIDTH-1:1]};
            OP_ROL:  res = {r[WIDTH-1], r[WIDTH-2:0], r[WIDTH-1]};
            OP_SRL:  res = {r[0],       1'b0,       r[WIDTH-1:1]};
            OP_SLL:  res = {r[WIDTH-1], r[WIDTH-2:0], 1'b0};
            OP_SRA:  res = {r[0],       r[WIDTH-1], r[WIDTH-1:1]};
            default: res = {1'b0, r};
        endcase
        return res;
    endfunction

`ifdef SEQ_SHIFTER_BARREL_EN
    localparam int unsigned MAX_AMT = (32'd1 << AMT_W) - 32'd1;

    // Unrolled chain of conditional steps: reuses step_f so the flags and
    // the amount >= WIDTH cases match the iterative path exactly.
    function automatic logic [WIDTH:0] barrel_f(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [AMT_W-1:0] amt);
        logic [WIDTH:0] acc;
        acc = {1'b0, a};
        for (int unsigned i = 0; i < MAX_AMT; i++) begin
            if (AMT_W'(i) < amt) begin
                acc = step_f(op, acc[WIDTH-1:0]);
            end
        end
        return acc;
    endfunction
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [2:0]         op_q, op_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   out_y_q, out_y_d;
    logic               out_zero_q, out_zero_d;
    logic               out_carry_q, out_carry_d;
    logic [WIDTH:0]     step_res;
`ifdef SEQ_SHIFTER_BARREL_EN
    logic [WIDTH:0]     barrel_res;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            r_q         <= '0;
            op_q        <= OP_PASS;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_y_q     <= '0;
            out_zero_q  <= 1'b0;
            out_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            out_y_q     <= out_y_d;
            out_zero_q  <= out_zero_d;
            out_carry_q <= out_carry_d;
        end
    end

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        out_y_d     = out_y_q;
        out_zero_d  = out_zero_q;
        out_carry_d = out_carry_q;
        step_res    = step_f(op_q, r_q);
`ifdef SEQ_SHIFTER_BARREL_EN
        barrel_res  = barrel_f(in_op, in_a, in_amt);
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = in_op;
`ifdef SEQ_SHIFTER_BARREL_EN
                    r_d     = barrel_res[WIDTH-1:0];
                    carry_d = barrel_res[WIDTH];
                    cnt_d   = '0;
                    state_d = DONE;
`else
                    r_d     = in_a;
                    carry_d = 1'b0;
                    cnt_d   = in_amt;
                    state_d = (in_amt != '0) ? SHIFT : DONE;
`endif
                end
            end
            SHIFT: begin
                r_d     = step_res[WIDTH-1:0];
                carry_d = step_res[WIDTH];
                cnt_d   = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Result registers load once, on entry to DONE, and hold after.
        if ((state_d == DONE) && (state_q != DONE)) begin
            out_y_d     = r_d;
            out_zero_d  = (r_d == '0);
            out_carry_d = carry_d;
        end

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_y     = out_y_q;
    assign out_zero  = out_zero_q;
    assign out_carry = out_carry_q;

endmodule

// File: tb/tb_seq_shifter.sv
// -----------------------------------------------------------------------------
// tb_seq_shifter
// Self-checking bench for seq_shifter (WIDTH=7, AMT_W=3). Expected results
// come from an arithmetic reference model and are queued at request time,
// then popped and compared when the unit presents out_valid.
// -----------------------------------------------------------------------------
module tb_seq_shifter;

    localparam int W = 7;

`ifdef SEQ_SHIFTER_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ROR  = 3'b001;
    localparam logic [2:0] OP_ROL  = 3'b010;
    localparam logic [2:0] OP_SRL  = 3'b011;
    localparam logic [2:0] OP_SLL  = 3'b100;
    localparam logic [2:0] OP_SRA  = 3'b101;

    typedef struct packed {
        logic [6:0] y;
        logic       zero;
        logic       carry;
        logic [2:0] amt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_a;
    logic [2:0] in_op;
    logic [2:0] in_amt;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_y;
    logic       out_zero;
    logic       out_carry;
    logic       busy;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;

    seq_shifter #(.WIDTH(7), .AMT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_op     (in_op),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_zero  (out_zero),
        .out_carry (out_carry),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Arithmetic reference: whole-amount shifts, not step-by-step.
    function automatic exp_t model(input logic [6:0] a, input logic [2:0] op,
                                   input logic [2:0] amt);
        exp_t        e;
        int unsigned ua;
        int          n;
        int          k;
        int          sa;
        ua = 32'(a);
        n  = int'(amt);
        k  = n % W;
        case (op)
            OP_ROR: begin
                e.y     = 7'((ua >> k) | (ua << (W - k)));
                e.carry = (n == 0) ? 1'b0 : e.y[6];
            end
            OP_ROL: begin
                e.y     = 7'((ua << k) | (ua >> (W - k)));
                e.carry = (n == 0) ? 1'b0 : e.y[0];
            end
            OP_SRL: begin
                e.y     = (n >= W) ? 7'd0 : 7'(ua >> n);
                e.carry = (n == 0) ? 1'b0 : ((n <= W) ? a[n-1] : 1'b0);
            end
            OP_SLL: begin
                e.y     = (n >= W) ? 7'd0 : 7'(ua << n);
                e.carry = (n == 0) ? 1'b0 : ((n <= W) ? a[W-n] : 1'b0);
            end
            OP_SRA: begin
                sa      = a[6] ? (int'(ua) - 128) : int'(ua);
                e.y     = 7'(sa >>> n);
                e.carry = (n == 0) ? 1'b0 : ((n <= W) ? a[n-1] : a[6]);
            end
            default: begin
                e.y     = a;
                e.carry = 1'b0;
            end
        endcase
        e.zero = (e.y == 7'd0);
        e.amt  = amt;
        return e;
    endfunction

    // Drive one request; returns at the falling edge after the accept edge.
    task automatic send(input logic [6:0] a, input logic [2:0] op, input logic [2:0] amt);
        int guard;
        guard = 0;
        while (!in_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_a     = a;
        in_op    = op;
        in_amt   = amt;
        q.push_back(model(a, op, amt));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int start, output int lat);
        lat = start;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        int   lat;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_y, out_zero, out_carry, busy} !== {1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_values: got rdy=%b vld=%b y=%b z=%b c=%b busy=%b required 1 0 0000000 0 0 0",
                     in_ready, out_valid, out_y, out_zero, out_carry, busy);
        end
        rst = 1'b0;
        @(negedge clk);
        send(7'b1010110, OP_ROL, 3'd5);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_mid_op: busy=%b required 1", busy);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, out_y, out_zero, out_carry, busy} !== {1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_mid_shift: got rdy=%b vld=%b y=%b z=%b c=%b busy=%b required 1 0 0000000 0 0 0",
                     in_ready, out_valid, out_y, out_zero, out_carry, busy);
        end
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(7'b1010110, OP_ROL, 3'd5);
        wait_valid(0, lat);
        e = q.pop_front();
        checks++;
        if ({out_valid, out_y, out_zero, out_carry} !== {1'b1, e.y, e.zero, e.carry}) begin
            fails++;
            $display("FAIL after_reset_rol5: got v=%b y=%b z=%b c=%b required 1 %b %b %b",
                     out_valid, out_y, out_zero, out_carry, e.y, e.zero, e.carry);
        end
        checks++;
        if (lat !== (BARREL ? 0 : 5)) begin
            fails++;
            $display("FAIL after_reset_latency: got %0d required %0d", lat, BARREL ? 0 : 5);
        end
        accept();
    endtask

    task automatic test_ror_hold();
        exp_t e;
        int   lat;
        send(7'b1010110, OP_ROR, 3'd1);
        wait_valid(0, lat);
        e = q.pop_front();
        checks++;
        if ({out_valid, out_y, out_zero, out_carry} !== {1'b1, 7'b0101011, 1'b0, 1'b0} ||
            {out_y, out_zero, out_carry} !== {e.y, e.zero, e.carry}) begin
            fails++;
            $display("FAIL ror1_result: got v=%b y=%b z=%b c=%b required 1 0101011 0 0",
                     out_valid, out_y, out_zero, out_carry);
        end
        checks++;
        if (lat !== (BARREL ? 0 : 1)) begin
            fails++;
            $display("FAIL ror1_latency: got %0d required %0d", lat, BARREL ? 0 : 1);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, out_y, out_zero, out_carry} !== {1'b1, 1'b0, e.y, e.zero, e.carry}) begin
                fails++;
                $display("FAIL ror1_hold[%0d]: got v=%b rdy=%b y=%b z=%b c=%b required 1 0 %b %b %b",
                         i, out_valid, in_ready, out_y, out_zero, out_carry, e.y, e.zero, e.carry);
            end
        end
        accept();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL ror1_release: got v=%b rdy=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_rol();
        exp_t e;
        int   lat;
        send(7'b1010110, OP_ROL, 3'd1);
        wait_valid(0, lat);
        e = q.pop_front();
        checks++;
        if ({out_y, out_carry} !== 8'b0101101_1 || {out_y, out_zero, out_carry} !== {e.y, e.zero, e.carry}) begin
            fails++;
            $display("FAIL rol1_result: got y=%b z=%b c=%b required 0101101 0 1", out_y, out_zero, out_carry);
        end
        accept();
    endtask

    task automatic test_sra_ignore();
        exp_t e;
        int   lat;
        send(7'b1010110, OP_SRA, 3'd3);
        checks++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL sra_in_ready_low: got %b required 0", in_ready);
        end
        in_valid = 1'b1;
        in_a     = 7'b1111111;
        in_op    = OP_ROR;
        in_amt   = 3'd1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(1, lat);
        e = q.pop_front();
        checks++;
        if ({out_y, out_zero, out_carry} !== {7'b1111010, 1'b0, 1'b1} ||
            {out_y, out_zero, out_carry} !== {e.y, e.zero, e.carry}) begin
            fails++;
            $display("FAIL sra3_result: got y=%b z=%b c=%b required 1111010 0 1", out_y, out_zero, out_carry);
        end
        checks++;
        if (lat !== (BARREL ? 1 : 3)) begin
            fails++;
            $display("FAIL sra3_latency: got %0d required %0d", lat, BARREL ? 1 : 3);
        end
        accept();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL sra_ignored_req[%0d]: got v=%b busy=%b required 0 0", i, out_valid, busy);
            end
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        int   lat;
        send(7'b1010110, OP_ROR, 3'd7);
        wait_valid(0, lat);
        e = q.pop_front();
        checks++;
        if ({out_y, out_zero, out_carry} !== {7'b1010110, 1'b0, 1'b1} ||
            {out_y, out_zero, out_carry} !== {e.y, e.zero, e.carry}) begin
            fails++;
            $display("FAIL ror7_result: got y=%b z=%b c=%b required 1010110 0 1", out_y, out_zero, out_carry);
        end
        accept();
        send(7'b1010110, OP_SLL, 3'd7);
        wait_valid(0, lat);
        e = q.pop_front();
        checks++;
        if ({out_y, out_zero, out_carry} !== {7'b0000000, 1'b1, 1'b0} ||
            {out_y, out_zero, out_carry} !== {e.y, e.zero, e.carry}) begin
            fails++;
            $display("FAIL sll7_result: got y=%b z=%b c=%b required 0000000 1 0", out_y, out_zero, out_carry);
        end
        checks++;
        if (lat !== (BARREL ? 0 : 7)) begin
            fails++;
            $display("FAIL sll7_latency: got %0d required %0d", lat, BARREL ? 0 : 7);
        end
        accept();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        int   accepts;
        int   results;
        send(7'b1010110, OP_SRL, 3'd0);
        wait_valid(0, lat);
        e = q.pop_front();
        checks++;
        if ({out_y, out_zero, out_carry} !== {7'b1010110, 1'b0, 1'b0} || lat !== 0) begin
            fails++;
            $display("FAIL srl0_result: got y=%b z=%b c=%b lat=%0d required 1010110 0 0 lat 0",
                     out_y, out_zero, out_carry, lat);
        end
        accept();
        accepts   = 0;
        results   = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_a   = 7'($urandom_range(127, 0));
            in_op  = OP_SRL;
            in_amt = 3'd0;
            checks++;
            if (in_ready && out_valid) begin
                fails++;
                $display("FAIL b2b_overlap[%0d]: in_ready=1 and out_valid=1 together", i);
            end
            if (out_valid) begin
                results++;
                checks++;
                e = (q.size() > 0) ? q.pop_front() : '0;
                if ({out_y, out_zero, out_carry} !== {e.y, e.zero, e.carry}) begin
                    fails++;
                    $display("FAIL b2b_result[%0d]: got y=%b z=%b c=%b required %b %b %b",
                             i, out_y, out_zero, out_carry, e.y, e.zero, e.carry);
                end
            end
            if (in_ready) begin
                accepts++;
                q.push_back(model(in_a, in_op, in_amt));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (accepts !== 5 || results !== 5 || q.size() !== 0) begin
            fails++;
            $display("FAIL b2b_rate: got accepts=%0d results=%0d pending=%0d required 5 5 0",
                     accepts, results, q.size());
        end
    endtask

    task automatic test_random();
        exp_t        e;
        int          lat;
        logic [6:0]  a;
        logic [2:0]  op;
        logic [2:0]  amt;
        for (int i = 0; i < 30; i++) begin
            a   = 7'($urandom_range(127, 0));
            op  = 3'($urandom_range(7, 0));
            amt = 3'($urandom_range(7, 0));
            send(a, op, amt);
            wait_valid(0, lat);
            e = q.pop_front();
            checks++;
            if ({out_valid, out_y, out_zero, out_carry} !== {1'b1, e.y, e.zero, e.carry}) begin
                fails++;
                $display("FAIL rand[%0d] a=%b op=%0d amt=%0d: got v=%b y=%b z=%b c=%b required 1 %b %b %b",
                         i, a, op, amt, out_valid, out_y, out_zero, out_carry, e.y, e.zero, e.carry);
            end
            checks++;
            if (lat !== (BARREL ? 0 : int'(e.amt))) begin
                fails++;
                $display("FAIL rand_latency[%0d]: got %0d required %0d", i, lat, BARREL ? 0 : int'(e.amt));
            end
            repeat ($urandom_range(2, 0)) @(negedge clk);
            accept();
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_op     = '0;
        in_amt    = '0;
        out_ready = 1'b0;
        test_reset();
        test_ror_hold();
        test_rol();
        test_sra_ignore();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Parametrised multi-cycle shift/rotate unit for the ALU datapath.
- Successor to the fixed 7-bit single-position rotator.
- Accepts an operand, an operation and a shift amount over a valid/ready handshake, then shifts one position per clock.
- Presents the result with zero and carry flags through a held output handshake.

Parameters:
- WIDTH, 7: operand/result width in bits (>= 2).
- AMT_W, 3: shift-amount width; amount range 0 .. 2^AMT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand/op/amount valid.
- in_ready  output  1  unit can accept a new request.
- in_a  input  WIDTH  operand.
- in_op  input  3  operation: 000 pass, 001 ROR, 010 ROL, 011 SRL, 100 SLL, 101 SRA; 110/111 treated as pass.
- in_amt  input  AMT_W  number of single-bit steps.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts result.
- out_y  output  WIDTH  result.
- out_zero  output  1  out_y == 0.
- out_carry  output  1  last bit shifted or rotated out; 0 if no step was taken.
- busy  output  1  state != IDLE.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high, named rst; clock is clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_y=0, out_zero=0, out_carry=0, busy=0, internal counter=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture in_a, in_op and in_amt into registers; clear carry.
  - Next state is SHIFT if in_amt != 0 (counter=in_amt), else DONE.
- SHIFT:
  - in_ready=0. Each cycle performs exactly one step on the working register and decrements the counter.
  - When the counter reaches 0 after a step, go to DONE.
- Step definitions (r = working register, c = carry):
  - ROR: r={r[0], r[W-1:1]}, c=r[0].
  - ROL: r={r[W-2:0], r[W-1]}, c=r[W-1].
  - SRL: r={0, r[W-1:1]}, c=r[0].
  - SLL: r={r[W-2:0], 0}, c=r[W-1].
  - SRA: r={r[W-1], r[W-1:1]}, c=r[0].
  - Pass and reserved ops: r unchanged, c=0. Pass still consumes in_amt cycles.
- DONE:
  - out_valid=1. out_y, out_zero and out_carry are stable and registered.
  - On an edge with out_ready=1, return to IDLE and drop out_valid.
  - While out_ready=0, hold all outputs indefinitely.
- Latency: request accepted at edge k; out_valid is high after edge k+in_amt, i.e. in_amt+1 cycles including the capture edge. For in_amt=0, out_valid is high after edge k.
- Throughput: next request is accepted no earlier than the edge after the result is accepted. in_ready is low during SHIFT and DONE, so there are no simultaneous accept/deliver cycles.
- Amount >= WIDTH:
  - Rotates wrap naturally; ROR by WIDTH returns the operand.
  - SRL/SLL produce all zeros.
  - SRA produces all sign bits.
- in_valid while not in IDLE is ignored; the input is not captured.
- Reset asserted mid-operation aborts immediately to reset values; the partial result is discarded.
- out_zero is computed from the final out_y, not from the operand.

Optional Feature:
- Macro: SEQ_SHIFTER_BARREL_EN.
- Defined:
  - A combinational barrel stage computes the full in_amt shift at capture.
  - IDLE goes directly to DONE for every amount, so latency is always 1 edge.
  - out_y and out_carry must be bit-identical to the iterative result, including amount >= WIDTH cases.
  - The SHIFT state is unreachable.
- Undefined: iterative behaviour as specified above.

Test Plan:
- Reset mid-SHIFT (ROL amt=5, rst at cycle 2) -> all outputs at reset values; next request behaves normally.
- a=1010110, op=ROR, amt=1 -> out_y=0101011, carry=0, zero=0, out_valid after 1 edge; with out_ready held low for 4 cycles, outputs are stable.
- a=1010110, op=ROL, amt=1 -> out_y=0101101, carry=1.
- a=1010110, op=SRA, amt=3 -> out_y=1111010, carry=1, out_valid 3 edges after accept; in_valid pulses during SHIFT are ignored.
- a=1010110, op=ROR, amt=7 -> out_y=1010110. a=1010110, op=SLL, amt=7 -> out_y=0000000, zero=1, carry=0.
- a=1010110, op=SRL, amt=0 -> out_y=1010110, carry=0, out_valid after 1 edge; back-to-back requests with out_ready=1 are accepted every other cycle minimum.
